// File: rtl/id_ex_operand_stage.sv
// ID/EX register with operand forwarding and load-use bubbles.
// `EX_FWD_EN enables forwarding; otherwise any RAW on EX/EX-MEM stalls.
module id_ex_operand_stage #(
   parameter int DW = 32,
   parameter int RW = 5,
   parameter int CW = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          id_valid,
   input  logic [RW-1:0] id_rs_addr,
   input  logic [RW-1:0] id_rt_addr,
   input  logic          id_use_rs,
   input  logic          id_use_rt,
   input  logic [DW-1:0] id_rs_data,
   input  logic [DW-1:0] id_rt_data,
   input  logic [DW-1:0] id_imm,
   input  logic [4:0]    id_shamt,
   input  logic          id_src1_shamt,
   input  logic          id_src2_imm,
   input  logic [CW-1:0] id_alu_ctl,
   input  logic          id_sign,
   input  logic [RW-1:0] id_wr_addr,
   input  logic          id_reg_write,
   input  logic          id_mem_read,
   input  logic          id_mem_write,
   input  logic          exm_reg_write,
   input  logic [RW-1:0] exm_wr_addr,
   input  logic [DW-1:0] exm_result,
   input  logic          mwb_reg_write,
   input  logic [RW-1:0] mwb_wr_addr,
   input  logic [DW-1:0] mwb_result,
   input  logic          flush,
   input  logic          ex_hold,
   output logic          stall_id,
   output logic [DW-1:0] alu_in1,
   output logic [DW-1:0] alu_in2,
   output logic [CW-1:0] alu_ctl,
   output logic          alu_sign,
   output logic          ex_valid,
   output logic [RW-1:0] ex_wr_addr,
   output logic          ex_reg_write,
   output logic          ex_mem_read,
   output logic          ex_mem_write,
   output logic [DW-1:0] ex_store_data
);

   typedef struct packed {
      logic          valid;
      logic [RW-1:0] rs_addr;
      logic [RW-1:0] rt_addr;
      logic [DW-1:0] rs_data;
      logic [DW-1:0] rt_data;
      logic [DW-1:0] imm;
      logic [4:0]    shamt;
      logic          src1_shamt;
      logic          src2_imm;
      logic [CW-1:0] alu_ctl;
      logic          sign;
      logic [RW-1:0] wr_addr;
      logic          reg_write;
      logic          mem_read;
      logic          mem_write;
   } id_ex_t;

   id_ex_t        ex_q;
   id_ex_t        id_d;
   logic          hazard;
   logic [DW-1:0] fwd_rs;
   logic [DW-1:0] fwd_rt;

   always_comb begin
      id_d            = '0;
      id_d.valid      = id_valid;
      id_d.rs_addr    = id_rs_addr;
      id_d.rt_addr    = id_rt_addr;
      id_d.rs_data    = id_rs_data;
      id_d.rt_data    = id_rt_data;
      id_d.imm        = id_imm;
      id_d.shamt      = id_shamt;
      id_d.src1_shamt = id_src1_shamt;
      id_d.src2_imm   = id_src2_imm;
      id_d.alu_ctl    = id_alu_ctl;
      id_d.sign       = id_sign;
      id_d.wr_addr    = id_wr_addr;
      id_d.reg_write  = id_reg_write;
      id_d.mem_read   = id_mem_read;
      id_d.mem_write  = id_mem_write;
   end

`ifdef EX_FWD_EN
   function automatic logic [DW-1:0] pick(
      input logic [RW-1:0] a,
      input logic [DW-1:0] rf,
      input logic          ew,
      input logic [RW-1:0] ea,
      input logic [DW-1:0] er,
      input logic          mw,
      input logic [RW-1:0] ma,
      input logic [DW-1:0] mr
   );
      logic [DW-1:0] v;
      v = rf;
      if (ew && ea != '0 && ea == a)
         v = er;
      else if (mw && ma != '0 && ma == a)
         v = mr;
      return v;
   endfunction

   logic ld_rs;
   logic ld_rt;

   assign fwd_rs = pick(ex_q.rs_addr, ex_q.rs_data,
                        exm_reg_write, exm_wr_addr, exm_result,
                        mwb_reg_write, mwb_wr_addr, mwb_result);
   assign fwd_rt = pick(ex_q.rt_addr, ex_q.rt_data,
                        exm_reg_write, exm_wr_addr, exm_result,
                        mwb_reg_write, mwb_wr_addr, mwb_result);

   assign ld_rs  = id_use_rs && id_rs_addr == ex_q.wr_addr;
   assign ld_rt  = id_use_rt && id_rt_addr == ex_q.wr_addr;
   assign hazard = ex_q.valid && ex_q.mem_read
                && ex_q.wr_addr != '0 && id_valid
                && (ld_rs || ld_rt);
`else
   logic raw_rs;
   logic raw_rt;
   logic ex_wr;
   logic unused_nofwd;

   // No bypass: MEM/WB distance is covered by RF write-through.
   assign fwd_rs = ex_q.rs_data;
   assign fwd_rt = ex_q.rt_data;

   assign ex_wr  = ex_q.valid && ex_q.reg_write;
   assign raw_rs = id_use_rs && id_rs_addr != '0
                && ((ex_wr && id_rs_addr == ex_q.wr_addr)
                 || (exm_reg_write && id_rs_addr == exm_wr_addr));
   assign raw_rt = id_use_rt && id_rt_addr != '0
                && ((ex_wr && id_rt_addr == ex_q.wr_addr)
                 || (exm_reg_write && id_rt_addr == exm_wr_addr));
   assign hazard = id_valid && (raw_rs || raw_rt);

   assign unused_nofwd = ^{exm_result, mwb_reg_write,
                           mwb_wr_addr, mwb_result,
                           ex_q.rs_addr, ex_q.rt_addr};
`endif

   assign stall_id = ex_hold || (hazard && !flush);

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q <= '0;
      end else if (!ex_hold) begin
         if (flush || hazard) begin
            ex_q.valid     <= 1'b0;
            ex_q.reg_write <= 1'b0;
            ex_q.mem_read  <= 1'b0;
            ex_q.mem_write <= 1'b0;
         end else begin
            ex_q <= id_d;
         end
      end
   end

   assign alu_in1 = ex_q.src1_shamt
                  ? {{(DW-5){1'b0}}, ex_q.shamt}
                  : fwd_rs;
   assign alu_in2 = ex_q.src2_imm ? ex_q.imm : fwd_rt;

   assign alu_ctl       = ex_q.alu_ctl;
   assign alu_sign      = ex_q.sign;
   assign ex_valid      = ex_q.valid;
   assign ex_wr_addr    = ex_q.wr_addr;
   assign ex_reg_write  = ex_q.valid && ex_q.reg_write;
   assign ex_mem_read   = ex_q.valid && ex_q.mem_read;
   assign ex_mem_write  = ex_q.valid && ex_q.mem_write;
   assign ex_store_data = fwd_rt;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage.
// Covers both builds; `EX_FWD_EN selects the forwarding expectations.
module tb_id_ex_operand_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [4:0]  id_rs_addr, id_rt_addr;
   logic        id_use_rs, id_use_rt;
   logic [31:0] id_rs_data, id_rt_data, id_imm;
   logic [4:0]  id_shamt;
   logic        id_src1_shamt, id_src2_imm;
   logic [5:0]  id_alu_ctl;
   logic        id_sign;
   logic [4:0]  id_wr_addr;
   logic        id_reg_write, id_mem_read, id_mem_write;
   logic        exm_reg_write;
   logic [4:0]  exm_wr_addr;
   logic [31:0] exm_result;
   logic        mwb_reg_write;
   logic [4:0]  mwb_wr_addr;
   logic [31:0] mwb_result;
   logic        flush, ex_hold;
   logic        stall_id;
   logic [31:0] alu_in1, alu_in2;
   logic [5:0]  alu_ctl;
   logic        alu_sign, ex_valid;
   logic [4:0]  ex_wr_addr;
   logic        ex_reg_write, ex_mem_read, ex_mem_write;
   logic [31:0] ex_store_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_ex_operand_stage dut (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_imm(id_imm), .id_shamt(id_shamt),
      .id_src1_shamt(id_src1_shamt), .id_src2_imm(id_src2_imm),
      .id_alu_ctl(id_alu_ctl), .id_sign(id_sign),
      .id_wr_addr(id_wr_addr), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .exm_reg_write(exm_reg_write), .exm_wr_addr(exm_wr_addr),
      .exm_result(exm_result), .mwb_reg_write(mwb_reg_write),
      .mwb_wr_addr(mwb_wr_addr), .mwb_result(mwb_result),
      .flush(flush), .ex_hold(ex_hold), .stall_id(stall_id),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctl(alu_ctl),
      .alu_sign(alu_sign), .ex_valid(ex_valid),
      .ex_wr_addr(ex_wr_addr), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_store_data(ex_store_data)
   );

   typedef struct {
      logic        vld;
      logic [4:0]  rs, rt;
      logic        urs, urt;
      logic [31:0] rsd, rtd, imm;
      logic [4:0]  sh;
      logic        s1, s2;
      logic [5:0]  ctl;
      logic        sg;
      logic [4:0]  wr;
      logic        rw, mr, mw;
      logic [31:0] e_in1, e_in2, e_sd;
      logic        e_vld, e_rw, e_mw;
   } vec_t;

   vec_t vt[6];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_valid = 0; id_rs_addr = 0; id_rt_addr = 0;
      id_use_rs = 0; id_use_rt = 0; id_rs_data = 0;
      id_rt_data = 0; id_imm = 0; id_shamt = 0;
      id_src1_shamt = 0; id_src2_imm = 0; id_alu_ctl = 0;
      id_sign = 0; id_wr_addr = 0; id_reg_write = 0;
      id_mem_read = 0; id_mem_write = 0;
      exm_reg_write = 0; exm_wr_addr = 0; exm_result = 0;
      mwb_reg_write = 0; mwb_wr_addr = 0; mwb_result = 0;
      flush = 0; ex_hold = 0;
   endtask

   task automatic rnd();
      logic [31:0] r;
      r = $urandom(); id_valid = r[0]; id_use_rs = r[1];
      id_use_rt = r[2]; id_src1_shamt = r[3]; id_src2_imm = r[4];
      id_sign = r[5]; id_reg_write = r[6]; id_mem_read = r[7];
      id_mem_write = r[8]; exm_reg_write = r[9];
      mwb_reg_write = r[10]; flush = r[11]; ex_hold = r[12];
      id_rs_addr = r[17:13]; id_rt_addr = r[22:18];
      id_wr_addr = r[27:23];
      r = $urandom(); id_alu_ctl = r[5:0]; id_shamt = r[10:6];
      exm_wr_addr = r[15:11]; mwb_wr_addr = r[20:16];
      id_rs_data = $urandom(); id_rt_data = $urandom();
      id_imm = $urandom(); exm_result = $urandom();
      mwb_result = $urandom();
   endtask

   task automatic apply(input vec_t v);
      id_valid = v.vld; id_rs_addr = v.rs; id_rt_addr = v.rt;
      id_use_rs = v.urs; id_use_rt = v.urt;
      id_rs_data = v.rsd; id_rt_data = v.rtd; id_imm = v.imm;
      id_shamt = v.sh; id_src1_shamt = v.s1; id_src2_imm = v.s2;
      id_alu_ctl = v.ctl; id_sign = v.sg; id_wr_addr = v.wr;
      id_reg_write = v.rw; id_mem_read = v.mr;
      id_mem_write = v.mw;
   endtask

   initial begin
      vt[0] = '{1,3,0,1,0,5,0,7,0,0,1,6'h00,0,10,1,0,0,
                5,7,0,1,1,0};
      vt[1] = '{1,1,2,1,1,'h100,'h23,0,0,0,0,6'h22,1,11,1,0,0,
                'h100,'h23,'h23,1,1,0};
      vt[2] = '{1,0,5,0,1,0,'hdeadbeef,0,31,1,0,6'h02,0,12,1,0,0,
                31,'hdeadbeef,'hdeadbeef,1,1,0};
      vt[3] = '{0,7,0,1,0,'h77,0,5,0,0,1,6'h20,0,13,1,0,1,
                'h77,5,0,0,0,0};
      vt[4] = '{1,4,6,1,1,'h1000,'hcafe,8,0,0,1,6'h20,0,0,0,0,1,
                'h1000,8,'hcafe,1,0,1};
      vt[5] = '{1,9,0,1,0,1,0,'hfffffffc,3,0,1,6'h2a,1,14,1,0,0,
                1,'hfffffffc,0,1,1,0};

      // reset with random inputs
      reset = 1;
      rnd();
      step();
      rnd();
      step();
      chk("rst_valid", ex_valid, 0);
      chk("rst_in1", alu_in1, 0);
      chk("rst_in2", alu_in2, 0);
      chk("rst_rw", ex_reg_write, 0);
      chk("rst_mr", ex_mem_read, 0);
      chk("rst_mw", ex_mem_write, 0);
      chk("rst_ctl", alu_ctl, 0);
      chk("rst_wr", ex_wr_addr, 0);
      reset = 0;
      idle();
      #1;
      chk("rst_stall", stall_id, 0);

      // table vectors, no forwarding sources active
      for (int i = 0; i < 6; i++) begin
         apply(vt[i]);
         #1;
         chk($sformatf("v%0d_stall", i), stall_id, 0);
         step();
         chk($sformatf("v%0d_in1", i), alu_in1, vt[i].e_in1);
         chk($sformatf("v%0d_in2", i), alu_in2, vt[i].e_in2);
         chk($sformatf("v%0d_sd", i), ex_store_data, vt[i].e_sd);
         chk($sformatf("v%0d_ctl", i), alu_ctl, vt[i].ctl);
         chk($sformatf("v%0d_sign", i), alu_sign, vt[i].sg);
         chk($sformatf("v%0d_wr", i), ex_wr_addr, vt[i].wr);
         chk($sformatf("v%0d_vld", i), ex_valid, vt[i].e_vld);
         chk($sformatf("v%0d_rw", i), ex_reg_write, vt[i].e_rw);
         chk($sformatf("v%0d_mw", i), ex_mem_write, vt[i].e_mw);
      end

      // forwarding priority on r8
      idle();
      id_valid = 1; id_rs_addr = 8; id_use_rs = 1;
      id_rs_data = 'h33; id_rt_addr = 8; id_use_rt = 1;
      id_rt_data = 'h44;
      step();
      idle();
      exm_reg_write = 1; exm_wr_addr = 8; exm_result = 'h11;
      mwb_reg_write = 1; mwb_wr_addr = 8; mwb_result = 'h22;
      #1;
`ifdef EX_FWD_EN
      chk("fwd_exm_in1", alu_in1, 'h11);
      chk("fwd_exm_sd", ex_store_data, 'h11);
`else
      chk("fwd_exm_in1", alu_in1, 'h33);
      chk("fwd_exm_sd", ex_store_data, 'h44);
`endif
      exm_reg_write = 0;
      #1;
`ifdef EX_FWD_EN
      chk("fwd_mwb_in1", alu_in1, 'h22);
`else
      chk("fwd_mwb_in1", alu_in1, 'h33);
`endif
      exm_reg_write = 1; exm_wr_addr = 0; mwb_wr_addr = 0;
      #1;
      chk("fwd_r0_in1", alu_in1, 'h33);
      chk("fwd_r0_sd", ex_store_data, 'h44);

      // load-use on rt
      idle();
      id_valid = 1; id_wr_addr = 4; id_reg_write = 1; id_mem_read = 1;
      step();
      chk("ld_mr", ex_mem_read, 1);
      idle();
      id_valid = 1; id_rs_addr = 1; id_use_rs = 1;
      id_rt_addr = 4; id_use_rt = 1;
      #1;
      chk("lu_stall", stall_id, 1);
      step();
      chk("lu_bub_vld", ex_valid, 0);
      chk("lu_bub_rw", ex_reg_write, 0);
      chk("lu_bub_mr", ex_mem_read, 0);
      chk("lu_release", stall_id, 0);
      step();
      chk("lu_issue", ex_valid, 1);

      // same pattern, rt not read
      idle();
      id_valid = 1; id_wr_addr = 4; id_reg_write = 1; id_mem_read = 1;
      step();
      idle();
      id_valid = 1; id_rs_addr = 1; id_use_rs = 1;
      id_rt_addr = 4; id_use_rt = 0;
      #1;
      chk("nouse_stall", stall_id, 0);
      step();
      chk("nouse_vld", ex_valid, 1);

      // flush beats load-use
      idle();
      id_valid = 1; id_wr_addr = 4; id_reg_write = 1; id_mem_read = 1;
      step();
      idle();
      id_valid = 1; id_rt_addr = 4; id_use_rt = 1; flush = 1;
      #1;
      chk("flush_stall", stall_id, 0);
      step();
      chk("flush_vld", ex_valid, 0);
      chk("flush_rw", ex_reg_write, 0);

      // ex_hold freezes EX for three cycles
      idle();
      id_valid = 1; id_rs_addr = 2; id_rs_data = 'haa;
      id_src2_imm = 1; id_imm = 'hbb; id_alu_ctl = 6'h21;
      step();
      chk("hold_pre_in1", alu_in1, 'haa);
      id_rs_data = 'h55; id_imm = 'h66; id_alu_ctl = 6'h00;
      ex_hold = 1;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("hold%0d_stall", c), stall_id, 1);
         step();
         chk($sformatf("hold%0d_in1", c), alu_in1, 'haa);
         chk($sformatf("hold%0d_in2", c), alu_in2, 'hbb);
         chk($sformatf("hold%0d_ctl", c), alu_ctl, 6'h21);
         chk($sformatf("hold%0d_vld", c), ex_valid, 1);
      end
      ex_hold = 0;
      step();
      chk("hold_rel_in1", alu_in1, 'h55);
      chk("hold_rel_in2", alu_in2, 'h66);
      chk("hold_rel_ctl", alu_ctl, 6'h00);

      // ALU result to r9 consumed by the next instruction
      idle();
      id_valid = 1; id_wr_addr = 9; id_reg_write = 1;
      id_alu_ctl = 6'h20;
      step();
      idle();
      id_valid = 1; id_rs_addr = 9; id_use_rs = 1; id_rs_data = 1;
      #1;
`ifdef EX_FWD_EN
      chk("raw_stall0", stall_id, 0);
      step();
      chk("raw_vld", ex_valid, 1);
      exm_reg_write = 1; exm_wr_addr = 9; exm_result = 'h99;
      #1;
      chk("raw_fwd_exm", alu_in1, 'h99);
      exm_reg_write = 0;
      mwb_reg_write = 1; mwb_wr_addr = 9; mwb_result = 'h99;
      #1;
      chk("raw_fwd_mwb", alu_in1, 'h99);
`else
      chk("raw_stall0", stall_id, 1);
      step();
      chk("raw_bub0", ex_valid, 0);
      exm_reg_write = 1; exm_wr_addr = 9; exm_result = 'h99;
      #1;
      chk("raw_stall1", stall_id, 1);
      step();
      chk("raw_bub1", ex_valid, 0);
      exm_reg_write = 0;
      mwb_reg_write = 1; mwb_wr_addr = 9; mwb_result = 'h99;
      id_rs_data = 'h99;
      #1;
      chk("raw_stall2", stall_id, 0);
      step();
      chk("raw_in1", alu_in1, 'h99);
      chk("raw_vld", ex_valid, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
